// File: rtl/dcache_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_if
// Description : CPU load/store, cache SRAM and main-memory signal bundle for
//               the data-cache controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface dcache_if;
    // CPU side
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic         cpu_memread_i;
    logic         cpu_memwrite_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    // Cache SRAM side
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o;
    logic [255:0] sram_data_o;
    logic         sram_enable_o;
    logic         sram_write_o;
    logic [24:0]  sram_tag_i;
    logic [255:0] sram_data_i;
    logic         sram_hit_i;
    // Main-memory side
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    modport slave (
        input  cpu_addr_i, cpu_data_i, cpu_memread_i, cpu_memwrite_i,
        output cpu_data_o, cpu_stall_o,
        output sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
        input  sram_tag_i, sram_data_i, sram_hit_i,
        output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
        input  mem_data_i, mem_ack_i
    );

    modport master (
        output cpu_addr_i, cpu_data_i, cpu_memread_i, cpu_memwrite_i,
        input  cpu_data_o, cpu_stall_o,
        input  sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
        output sram_tag_i, sram_data_i, sram_hit_i,
        input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
        output mem_data_i, mem_ack_i
    );
endinterface
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : dcache_controller
// Description : Write-back, write-allocate data-cache control stage: hit
//               service, dirty-victim writeback, line refill and replay.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_controller #(
    parameter int LINE_W  = 256,
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 23
) (
    input  wire   clk_i,
    input  wire   rst_i,
    dcache_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_MISS        = 3'd1,
        S_WRITEBACK   = 3'd2,
        S_REFILL      = 3'd3,
        S_REFILL_DONE = 3'd4
    } state_t;

    state_t              r_state;
    logic [TAG_W-1:0]    r_tag;
    logic [INDEX_W-1:0]  r_index;
    logic [LINE_W-1:0]   r_line;
    logic [LINE_W-1:0]   r_mem_data;
    logic [31:0]         r_mem_addr;
    logic                r_mem_enable;
    logic                r_mem_write;

    logic                w_req;
    logic                w_hit;
    logic                w_idle;
    logic                w_fill;
    logic                w_load_hit;
    logic                w_store_hit;
    logic [7:0]          w_bit;
    logic [LINE_W-1:0]   w_merged;
    logic                w_unused;

    assign w_req       = bus.cpu_memread_i | bus.cpu_memwrite_i;
    assign w_hit       = bus.sram_hit_i;
    // Reset gates the combinational strobes so every output reads 0 while held.
    assign w_idle      = (r_state == S_IDLE) & ~rst_i;
    assign w_fill      = (r_state == S_REFILL_DONE) & ~rst_i;
    assign w_load_hit  = w_idle & w_req & w_hit;
    assign w_store_hit = w_load_hit & bus.cpu_memwrite_i;
    assign w_bit       = {bus.cpu_addr_i[4:2], 5'b0};
    assign w_unused    = ^bus.cpu_addr_i[1:0];

    always_comb begin
        w_merged             = bus.sram_data_i;
        w_merged[w_bit +: 32] = bus.cpu_data_i;
    end

    assign bus.sram_addr_o   = bus.cpu_addr_i[8:5];
    assign bus.sram_enable_o = w_req & ~rst_i;
    assign bus.sram_write_o  = w_store_hit | w_fill;
    assign bus.sram_data_o   = w_fill      ? r_line :
                               w_store_hit ? w_merged : '0;
    assign bus.sram_tag_o    = w_fill      ? {2'b10, r_tag} :
                               w_store_hit ? {2'b11, bus.cpu_addr_i[31:9]} : '0;
    assign bus.cpu_data_o    = w_load_hit ? bus.sram_data_i[w_bit +: 32] : '0;
    assign bus.cpu_stall_o   = ~rst_i & ((r_state == S_IDLE) ? (w_req & ~w_hit) : 1'b1);

    assign bus.mem_addr_o    = r_mem_addr;
    assign bus.mem_data_o    = r_mem_data;
    assign bus.mem_enable_o  = r_mem_enable;
    assign bus.mem_write_o   = r_mem_write;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_tag        <= '0;
            r_index      <= '0;
            r_line       <= '0;
            r_mem_data   <= '0;
            r_mem_addr   <= '0;
            r_mem_enable <= 1'b0;
            r_mem_write  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Capture the missing address so a dropped request cannot
                    // redirect the refill half-way through.
                    if (w_req && !w_hit) begin
                        r_tag   <= bus.cpu_addr_i[31:9];
                        r_index <= bus.cpu_addr_i[8:5];
                        r_state <= S_MISS;
                    end
                end
                S_MISS: begin
                    r_mem_data   <= bus.sram_data_i;
                    r_mem_enable <= 1'b1;
                    if (bus.sram_tag_i[24] && bus.sram_tag_i[23]) begin
                        r_mem_write <= 1'b1;
                        r_mem_addr  <= {bus.sram_tag_i[22:0], r_index, 5'b0};
                        r_state     <= S_WRITEBACK;
                    end else begin
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= {r_tag, r_index, 5'b0};
                        r_state     <= S_REFILL;
                    end
                end
                S_WRITEBACK: begin
                    if (bus.mem_ack_i) begin
                        r_mem_enable <= 1'b0;
                        r_mem_write  <= 1'b0;
                        r_mem_addr   <= {r_tag, r_index, 5'b0};
                        r_state      <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    // Entered with enable low only after a writeback: that
                    // cycle is the mandatory gap before the refill request.
                    if (!r_mem_enable) begin
                        r_mem_enable <= 1'b1;
                    end else if (bus.mem_ack_i) begin
                        r_line       <= bus.mem_data_i;
                        r_mem_enable <= 1'b0;
                        r_state      <= S_REFILL_DONE;
                    end
                end
                S_REFILL_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_controller
// Description : Scoreboard bench: SRAM and memory models around the controller,
//               architectural word-memory reference, directed and random ops.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcache_if dif ();

    dcache_controller dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (dif)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Architectural view: the whole cache+memory system behaves as plain memory.
    logic [31:0]  aw        [bit [31:0]];
    logic [255:0] mem_lines [bit [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h0000_0124) return 32'hDEAD_BEEF;
        return (a * 32'h0100_0193) ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (aw.exists(w)) return aw[w];
        return init_word(w);
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] la);
        logic [255:0] l;
        if (mem_lines.exists(la)) return mem_lines[la];
        for (int i = 0; i < 8; i++) l[32*i +: 32] = init_word(la + 32'(4*i));
        return l;
    endfunction

    // 2-way SRAM model: presents hit way on a hit, LRU way on a miss.
    logic [24:0]  s_tag  [16][2] = '{default: '0};
    logic [255:0] s_data [16][2] = '{default: '0};
    logic         s_lru  [16]    = '{default: 1'b0};
    logic [3:0]   m_set;
    logic [22:0]  m_ctag;
    logic         m_h0, m_h1, m_way;
    logic [28:0]  swlog [$];

    always_comb begin
        m_set  = dif.sram_addr_o;
        m_ctag = dif.cpu_addr_i[31:9];
        m_h0   = s_tag[m_set][0][24] && (s_tag[m_set][0][22:0] == m_ctag);
        m_h1   = s_tag[m_set][1][24] && (s_tag[m_set][1][22:0] == m_ctag);
        m_way  = m_h0 ? 1'b0 : (m_h1 ? 1'b1 : s_lru[m_set]);
        dif.sram_hit_i  = m_h0 | m_h1;
        dif.sram_tag_i  = s_tag[m_set][m_way];
        dif.sram_data_i = s_data[m_set][m_way];
    end

    always @(posedge clk) begin
        if (dif.sram_enable_o) begin
            if (dif.sram_write_o) begin
                s_tag[m_set][m_way]  <= dif.sram_tag_o;
                s_data[m_set][m_way] <= dif.sram_data_o;
                s_lru[m_set]         <= ~m_way;
                swlog.push_back({m_set, dif.sram_tag_o});
            end else if (dif.sram_hit_i) begin
                s_lru[m_set] <= ~m_way;
            end
        end
    end

    // Memory model with configurable latency; logs every completed transaction.
    typedef struct {
        logic [31:0]  addr;
        logic         wr;
        logic [255:0] data;
    } mtx_t;
    mtx_t mlog [$];
    int   lat      = 0;
    bit   rand_lat = 1'b0;
    bit   auto_ack = 1'b1;
    int   kick     = 0;

    initial begin
        int cnt, last_kick, gap;
        bit wb_seen;
        logic [255:0] el;
        mtx_t t;
        cnt = 0; last_kick = 0; gap = 0; wb_seen = 1'b0;
        dif.mem_ack_i  = 1'b0;
        dif.mem_data_i = '0;
        forever begin
            @(negedge clk);
            dif.mem_ack_i = 1'b0;
            if (kick != last_kick) begin
                last_kick      = kick;
                dif.mem_ack_i  = 1'b1;
                dif.mem_data_i = {8{32'hBAD0_0BAD}};
            end else if (auto_ack && !rst && dif.mem_enable_o) begin
                if (wb_seen) begin
                    chk("wb_refill_gap", 256'(gap), 256'd1);
                    wb_seen = 1'b0;
                end
                if (cnt >= lat) begin
                    cnt = 0;
                    dif.mem_ack_i = 1'b1;
                    t.addr = dif.mem_addr_o; t.wr = dif.mem_write_o; t.data = dif.mem_data_o;
                    mlog.push_back(t);
                    chk("mem_addr_align", 256'(dif.mem_addr_o[4:0]), 256'd0);
                    if (dif.mem_write_o) begin
                        for (int i = 0; i < 8; i++) el[32*i +: 32] = exp_word(dif.mem_addr_o + 32'(4*i));
                        chk("writeback_line", dif.mem_data_o, el);
                        mem_lines[dif.mem_addr_o] = dif.mem_data_o;
                        wb_seen = 1'b1;
                        gap     = 0;
                    end else begin
                        dif.mem_data_i = mem_line(dif.mem_addr_o);
                    end
                    lat = rand_lat ? int'($urandom_range(0, 3)) : 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
                if (wb_seen) gap++;
            end
        end
    end

    // Scoreboard: expectations pushed at issue, popped on each completion.
    typedef struct {
        bit          st;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t sb [$];

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (dif.cpu_memread_i || dif.cpu_memwrite_i) && !dif.cpu_stall_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL sb_unexpected: completion at %0h, expected no completion", dif.cpu_addr_i);
                end else begin
                    e = sb.pop_front();
                    chk("sb_addr", 256'(dif.cpu_addr_i), 256'(e.addr));
                    if (e.st) begin
                        chk("store_write", 256'(dif.sram_write_o), 256'd1);
                        chk("store_tag", 256'(dif.sram_tag_o), 256'({2'b11, e.addr[31:9]}));
                        chk("store_word", 256'(dif.sram_data_o[{e.addr[4:2], 5'b0} +: 32]), 256'(e.data));
                    end else begin
                        chk("load_data", 256'(dif.cpu_data_o), 256'(e.data));
                    end
                end
            end
        end
    end

    task automatic do_req(input bit st, input bit both, input logic [31:0] a,
                          input logic [31:0] d, output int cyc);
        exp_t e;
        e.st   = st;
        e.addr = a;
        e.data = st ? d : exp_word(a);
        sb.push_back(e);
        if (st) aw[{a[31:2], 2'b00}] = d;
        @(posedge clk); #1;
        dif.cpu_addr_i     = a;
        dif.cpu_data_i     = d;
        dif.cpu_memwrite_i = st;
        dif.cpu_memread_i  = ~st | both;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (!dif.cpu_stall_o) break;
            cyc++;
            if (cyc > 100) begin
                checks++;
                fails++;
                $display("FAIL req_timeout: addr %0h still stalled after %0d cycles, expected completion", a, cyc);
                break;
            end
        end
        @(posedge clk); #1;
        dif.cpu_memread_i  = 1'b0;
        dif.cpu_memwrite_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        dif.cpu_addr_i     = '0;
        dif.cpu_data_i     = '0;
        dif.cpu_memread_i  = 1'b0;
        dif.cpu_memwrite_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_strobes", 256'({dif.cpu_stall_o, dif.mem_enable_o, dif.mem_write_o,
                                   dif.sram_write_o, dif.sram_enable_o}), 256'd0);
        chk("reset_data", 256'({dif.cpu_data_o, dif.mem_addr_o}), 256'd0);
        rst = 1'b0;

        // 1: cold load, clean victim
        do_req(1'b0, 1'b0, 32'h0000_0124, 32'h0, cyc);
        chk("t1_stall_cycles", 256'(cyc), 256'd4);
        chk("t1_mlog_size", 256'(mlog.size()), 256'd1);
        if (mlog.size() >= 1) chk("t1_refill", 256'({mlog[0].addr, mlog[0].wr}), 256'({32'h0000_0120, 1'b0}));
        chk("t1_fill_tag", 256'(swlog[swlog.size()-1]), 256'({4'd9, 25'h100_0000}));

        // 2: store hit
        do_req(1'b1, 1'b0, 32'h0000_012C, 32'h1234_5678, cyc);
        chk("t2_stall_cycles", 256'(cyc), 256'd0);
        chk("t2_no_mem", 256'(mlog.size()), 256'd1);

        // 3: fill the other way, then evict the dirty line
        do_req(1'b0, 1'b0, 32'h0000_0320, 32'h0, cyc);
        chk("t3_first_cycles", 256'(cyc), 256'd4);
        do_req(1'b0, 1'b0, 32'h0000_0520, 32'h0, cyc);
        chk("t3_second_cycles", 256'(cyc), 256'd6);
        chk("t3_mlog_size", 256'(mlog.size()), 256'd4);
        if (mlog.size() >= 4) begin
            chk("t3_refill_320", 256'({mlog[1].addr, mlog[1].wr}), 256'({32'h0000_0320, 1'b0}));
            chk("t3_writeback", 256'({mlog[2].addr, mlog[2].wr}), 256'({32'h0000_0120, 1'b1}));
            chk("t3_wb_word3", 256'(mlog[2].data[127:96]), 256'(32'h1234_5678));
            chk("t3_refill_520", 256'({mlog[3].addr, mlog[3].wr}), 256'({32'h0000_0520, 1'b0}));
        end

        // 4: store miss, write-allocate then replay
        do_req(1'b1, 1'b0, 32'h0000_0040, 32'hA5A5_A5A5, cyc);
        chk("t4_stall_cycles", 256'(cyc), 256'd4);
        chk("t4_refill", 256'({mlog[mlog.size()-1].addr, mlog[mlog.size()-1].wr}), 256'({32'h0000_0040, 1'b0}));
        chk("t4_fill_clean", 256'(swlog[swlog.size()-2]), 256'({4'd2, 25'h100_0000}));
        chk("t4_replay_dirty", 256'(swlog[swlog.size()-1]), 256'({4'd2, 25'h180_0000}));

        // 5: reset in the middle of a refill, then a stale ack
        auto_ack = 1'b0;
        @(posedge clk); #1;
        dif.cpu_addr_i    = 32'h0000_1000;
        dif.cpu_memread_i = 1'b1;
        begin
            int w;
            w = 0;
            while (!dif.mem_enable_o && w < 50) begin
                @(negedge clk);
                w++;
            end
        end
        chk("t5_refill_req", 256'({dif.mem_enable_o, dif.mem_write_o, dif.mem_addr_o}),
            256'({1'b1, 1'b0, 32'h0000_1000}));
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("t5_async_drop", 256'({dif.mem_enable_o, dif.sram_write_o, dif.cpu_stall_o}), 256'd0);
        dif.cpu_memread_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        kick++;
        repeat (3) begin
            @(negedge clk);
            chk("t5_stale_ack_quiet", 256'({dif.sram_write_o, dif.mem_enable_o, dif.cpu_stall_o}), 256'd0);
        end
        do_req(1'b0, 1'b0, 32'h0000_0320, 32'h0, cyc);
        chk("t5_idle_hit", 256'(cyc), 256'd0);

        // 6: ack with no request in IDLE
        @(posedge clk); #1;
        kick++;
        repeat (3) begin
            @(negedge clk);
            chk("t6_idle_ack_quiet", 256'({dif.sram_enable_o, dif.sram_write_o,
                                           dif.mem_enable_o, dif.cpu_stall_o}), 256'd0);
        end
        auto_ack = 1'b1;
        do_req(1'b0, 1'b0, 32'h0000_0520, 32'h0, cyc);
        chk("t6_idle_hit", 256'(cyc), 256'd0);

        // Random traffic over 4 tags x 4 sets to force conflicts and evictions
        rand_lat = 1'b1;
        for (int n = 0; n < 250; n++) begin
            logic [31:0] a;
            bit st, both;
            a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 5) |
                (32'($urandom_range(0, 7)) << 2);
            st   = ($urandom_range(0, 99) < 45);
            both = st && ($urandom_range(0, 9) == 0);
            do_req(st, both, a, $urandom, cyc);
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", 256'(sb.size()), 256'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Data-cache control stage between the CPU load/store port and the 2-way, 16-set, 256-bit-line cache SRAM; also drives the main-memory port.
- Detects hit/miss through the SRAM hit flag and stalls the CPU on a miss.
- Writes back a dirty victim line, refills from memory, then replays the access.
- Policy: write-back, write-allocate.

Parameters:
- LINE_W, 256, cache line width in bits (32 bytes).
- INDEX_W, 4, set index width (16 sets).
- TAG_W, 23, address tag width. The SRAM tag field is TAG_W+2 bits: {valid, dirty, tag}.
- Only the default parameter values are supported and verified.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- cpu_addr_i  in  32  byte address; [31:9] tag, [8:5] index, [4:2] word select, [1:0] ignored
- cpu_data_i  in  32  store data
- cpu_memread_i  in  1  load request; held by the CPU while stalled
- cpu_memwrite_i  in  1  store request; held by the CPU while stalled
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  CPU must hold its request
- sram_addr_o  out  4  set index to the SRAM
- sram_tag_o  out  25  {valid, dirty, tag} to the SRAM
- sram_data_o  out  256  line to write into the SRAM
- sram_enable_o  out  1  SRAM access enable
- sram_write_o  out  1  SRAM write strobe
- sram_tag_i  in  25  SRAM tag: hit way on a hit, LRU victim way on a miss
- sram_data_i  in  256  SRAM line: hit way on a hit, LRU victim way on a miss
- sram_hit_i  in  1  SRAM hit flag
- mem_addr_o  out  32  line address to memory, low 5 bits always 0
- mem_data_o  out  256  writeback line
- mem_enable_o  out  1  memory request, held until acknowledged
- mem_write_o  out  1  1 = writeback, 0 = refill read
- mem_data_i  in  256  refill line, valid in the mem_ack_i cycle
- mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- req = cpu_memread_i | cpu_memwrite_i.
- sram_addr_o = cpu_addr_i[8:5].
- sram_enable_o = req in every state.
- States: IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE. Reset value is IDLE.
- Reset values: all outputs 0; no internal pending flags survive reset.
- IDLE:
  - cpu_stall_o = req & ~sram_hit_i.
  - Load hit: cpu_data_o = sram_data_i[32k+31:32k], k = cpu_addr_i[4:2], combinational, zero-latency.
  - Store hit: sram_write_o = 1 in the same cycle; sram_data_o = sram_data_i with word k replaced by cpu_data_i; sram_tag_o = {1, 1, cpu_addr_i[31:9]}.
  - On req & ~hit: go to MISS.
  - No req: all strobes 0.
- MISS (1 cycle):
  - Victim tag and line are latched.
  - If victim valid & dirty (sram_tag_i[24] & sram_tag_i[23]): go to WRITEBACK.
  - Else: go to REFILL.
- WRITEBACK:
  - mem_enable_o = 1, mem_write_o = 1.
  - mem_addr_o = {victim tag, index, 5'b0}; mem_data_o = latched victim line.
  - On mem_ack_i: go to REFILL; mem_enable_o drops for exactly one cycle before the refill request.
- REFILL:
  - mem_enable_o = 1, mem_write_o = 0.
  - mem_addr_o = {cpu_addr_i[31:9], index, 5'b0}.
  - On mem_ack_i: latch mem_data_i and go to REFILL_DONE.
- REFILL_DONE (1 cycle):
  - sram_write_o = 1, sram_data_o = latched line, sram_tag_o = {1, 0, cpu tag}. The SRAM places the line in its LRU way.
  - Next state: IDLE. The held request then hits, and a store replays as a store hit, setting dirty.
- cpu_stall_o = 1 in MISS, WRITEBACK, REFILL and REFILL_DONE.
- mem_ack_i outside WRITEBACK or REFILL is ignored.
- mem_enable_o is never asserted in IDLE or MISS.
- A request dropped while the FSM is outside IDLE does not abort the sequence. The refill still completes and the FSM returns to IDLE.
- Simultaneous cpu_memread_i and cpu_memwrite_i: treated as a store.
- Reset mid-operation: the FSM goes to IDLE and mem_enable_o / sram_write_o drop asynchronously. A memory transaction in flight is abandoned, and a later ack is ignored.

Test Plan:
1. Cold load 0x0000_0124 with memory line word1 = 0xDEAD_BEEF and clean victim -> MISS then REFILL with mem_addr_o = 0x0000_0120, mem_write_o = 0, no writeback; after ack, one REFILL_DONE cycle with tag {1,0,0x000000}; next IDLE cycle cpu_data_o = 0xDEAD_BEEF and stall = 0.
2. Store hit 0x1234_5678 to 0x0000_012C after test 1 -> sram_write_o = 1 in the same cycle, word3 replaced, tag {1,1,...}, stall = 0, mem_enable_o = 0.
3. Loads to 0x0000_0320 then 0x0000_0520 (same set 9, both ways filled, dirty line evicted) -> WRITEBACK first: mem_addr_o = 0x0000_0120, mem_data_o holds 0x1234_5678 in word3, mem_write_o = 1; then a one-cycle enable gap; then REFILL at 0x0000_0520.
4. Store miss 0x0000_0040 with data 0xA5A5_A5A5 -> refill read at 0x0000_0040, REFILL_DONE writes a clean line, replay writes word0 with dirty = 1; stall lasts exactly until the replay cycle.
5. rst_i pulsed mid-REFILL with a 10-cycle memory latency -> mem_enable_o = 0 immediately; a later mem_ack_i causes no SRAM write; state is IDLE.
6. mem_ack_i pulsed in IDLE with no request -> no state change, all strobes 0.
